// File: rtl/chroma_pkg.sv
// Shared widths, mode encodings and FSM states for the chroma-key stage.
package chroma_pkg;
  localparam int HUE_W       = 9;
  localparam int SV_W        = 15;
  localparam int PIX_W       = HUE_W + SV_W;
  localparam int SAT_W       = 7;
  localparam int COORD_W     = 13;
  localparam int HUE_MAX     = 360;
  localparam int SCROLL_STEP = 4;

  localparam logic [1:0] MODE_RAINBOW = 2'd0;
  localparam logic [1:0] MODE_SCROLL  = 2'd1;
  localparam logic [1:0] MODE_SOLID   = 2'd2;
  localparam logic [1:0] MODE_MASK    = 2'd3;

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/chroma_key_pipe_hue_wrap.sv
// Two-stage modulo-HUE_MAX reducer: conditional subtraction of HUE_MAX<<k,
// upper shifts in the first register stage, lower shifts in the second.
module hue_wrap #(
  parameter int IN_W    = 15,
  parameter int HUE_MAX = 360,
  parameter int OUT_W   = 9
) (
  input  logic             clk,
  input  logic [IN_W-1:0]  sum,
  output logic [OUT_W-1:0] hue
);
  function automatic int top_shift();
    int k;
    k = 0;
    while ((longint'(HUE_MAX) << (k + 1)) < (longint'(1) << IN_W)) k++;
    return k;
  endfunction

  localparam int K_HI  = top_shift();
  localparam int K_MID = K_HI / 2;
  localparam logic [IN_W-1:0] HM = IN_W'(HUE_MAX);

  function automatic logic [IN_W-1:0] reduce(input logic [IN_W-1:0] x, input int hi, input int lo);
    logic [IN_W-1:0] r;
    r = x;
    for (int k = hi; k >= lo; k--)
      if (r >= (HM << k)) r = r - (HM << k);
    return r;
  endfunction

  logic [IN_W-1:0]  part_q;
  logic [OUT_W-1:0] full_q;

  // Datapath only; validity is tracked by the caller's valid pipe.
  always_ff @(posedge clk) begin
    part_q <= reduce(sum, K_HI, K_MID + 1);
    full_q <= OUT_W'(reduce(part_q, K_MID, 0));
  end

  assign hue = full_q;
endmodule

// File: rtl/chroma_key_pipe.sv
// Chroma-key stage: hue-window key with optional saturation gate, four background
// modes, SOF-shadowed config, fixed 3-cycle latency.
module chroma_key_pipe #(
  parameter int HUE_W       = chroma_pkg::HUE_W,
  parameter int SV_W        = chroma_pkg::SV_W,
  parameter int SAT_W       = chroma_pkg::SAT_W,
  parameter int COORD_W     = chroma_pkg::COORD_W,
  parameter int HUE_MAX     = chroma_pkg::HUE_MAX,
  parameter int SCROLL_STEP = chroma_pkg::SCROLL_STEP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [COORD_W-1:0]       row,
  input  logic [COORD_W-1:0]       col,
  input  logic [HUE_W+SV_W-1:0]    pixel_in,
  input  logic [HUE_W+SV_W-1:0]    pass_in,
  input  logic                     key_en,
  input  logic [1:0]               mode,
  input  logic [HUE_W-1:0]         hue_lo,
  input  logic [HUE_W-1:0]         hue_hi,
  input  logic [SAT_W-1:0]         sat_min,
  input  logic [HUE_W-1:0]         solid_hue,
  output logic                     out_valid,
  output logic [HUE_W+SV_W-1:0]    pixel_out,
  output logic [HUE_W+SV_W-1:0]    pass_thru,
  output logic                     sof_seen
);
  import chroma_pkg::*;

  localparam int PIX_W  = HUE_W + SV_W;
  localparam int SUM_W  = COORD_W + 2;
  localparam int STAGES = 3;
  localparam logic [HUE_W:0] HMAX_X = (HUE_W+1)'(HUE_MAX);
  localparam logic [HUE_W:0] STEP_X = (HUE_W+1)'(SCROLL_STEP);

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic [PIX_W-1:0] pass;
    logic             key;
    logic [1:0]       mode;
    logic [HUE_W-1:0] solid;
  } stg_t;

  state_t state, state_nx;
  logic   sof;
  assign sof = in_valid && row == '0 && col == '0;

  always_comb begin
    state_nx = state;
    if (state == WAIT_SOF && sof) state_nx = ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nx;
  end

  logic             sh_key_en;
  logic [1:0]       sh_mode;
  logic [HUE_W-1:0] sh_lo, sh_hi, sh_solid, phase;
  logic [SAT_W-1:0] sh_sat;

  logic [HUE_W:0]   ph_sum;
  logic [HUE_W-1:0] phase_wr;
  assign ph_sum   = {1'b0, phase} + STEP_X;
  assign phase_wr = (ph_sum >= HMAX_X) ? HUE_W'(ph_sum - HMAX_X) : HUE_W'(ph_sum);

  // The SOF pixel sees the freshly latched config and phase.
  logic             e_key_en;
  logic [1:0]       e_mode;
  logic [HUE_W-1:0] e_lo, e_hi, e_solid, e_phase;
  logic [SAT_W-1:0] e_sat;

  always_comb begin
    e_key_en = sh_key_en;
    e_mode   = sh_mode;
    e_lo     = sh_lo;
    e_hi     = sh_hi;
    e_sat    = sh_sat;
    e_solid  = sh_solid;
    e_phase  = phase;
    if (sof) begin
      e_key_en = key_en;
      e_mode   = mode;
      e_lo     = hue_lo;
      e_hi     = hue_hi;
      e_sat    = sat_min;
      e_solid  = solid_hue;
      if (mode == MODE_SCROLL) e_phase = phase_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_key_en <= 1'b0;
      sh_mode   <= '0;
      sh_lo     <= '0;
      sh_hi     <= '0;
      sh_sat    <= '0;
      sh_solid  <= '0;
      phase     <= '0;
      sof_seen  <= 1'b0;
    end else if (sof) begin
      sh_key_en <= e_key_en;
      sh_mode   <= e_mode;
      sh_lo     <= e_lo;
      sh_hi     <= e_hi;
      sh_sat    <= e_sat;
      sh_solid  <= e_solid;
      phase     <= e_phase;
      sof_seen  <= 1'b1;
    end
  end

  logic [HUE_W-1:0] hue;
  logic [SAT_W-1:0] sat;
  logic             in_win;
  logic [SUM_W-1:0] sum0;
  stg_t             s0, s1, s2;

  assign hue = pixel_in[PIX_W-1 -: HUE_W];
  assign sat = pixel_in[SV_W-1 -: SAT_W];

  always_comb begin
    if (e_lo <= e_hi) in_win = hue >= e_lo && hue <= e_hi;
    else              in_win = hue >= e_lo || hue <= e_hi;
    s0.pix   = pixel_in;
    s0.pass  = pass_in;
    s0.key   = in_win && sat >= e_sat && e_key_en && (sof || state == ACTIVE);
    s0.mode  = e_mode;
    s0.solid = e_solid;
    sum0     = SUM_W'(row) + SUM_W'(col) + SUM_W'(e_phase);
  end

  logic [HUE_W-1:0] bg;
  hue_wrap #(.IN_W(SUM_W), .HUE_MAX(HUE_MAX), .OUT_W(HUE_W)) u_wrap (
    .clk (clk),
    .sum (sum0),
    .hue (bg)
  );

  logic [STAGES:1]  vld_pipe;
  logic [PIX_W-1:0] pix_nx;

  always_comb begin
    pix_nx = s2.pix;
    if (s2.key) begin
      case (s2.mode)
        MODE_RAINBOW, MODE_SCROLL: pix_nx = {bg, {SV_W{1'b1}}};
        MODE_SOLID:                pix_nx = {s2.solid, {SV_W{1'b1}}};
        default:                   pix_nx = '1;
      endcase
    end else if (s2.mode == MODE_MASK) begin
      pix_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1        <= '0;
      s2        <= '0;
      pixel_out <= '0;
      pass_thru <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
      s1        <= s0;
      s2        <= s1;
      pixel_out <= pix_nx;
      pass_thru <= s2.pass;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_chroma_key_pipe.sv
// Directed bench for chroma_key_pipe: streamed vector table plus phase, latency and reset sequences.
module tb_chroma_key_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, key_en;
  logic [12:0] row, col;
  logic [23:0] pixel_in, pass_in;
  logic [1:0]  mode;
  logic [8:0]  hue_lo, hue_hi, solid_hue;
  logic [6:0]  sat_min;
  logic        out_valid, sof_seen;
  logic [23:0] pixel_out, pass_thru;

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] SV   = 15'h7F12;
  localparam logic [14:0] ONES = 15'h7FFF;

  chroma_key_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .row(row), .col(col),
    .pixel_in(pixel_in), .pass_in(pass_in), .key_en(key_en), .mode(mode),
    .hue_lo(hue_lo), .hue_hi(hue_hi), .sat_min(sat_min), .solid_hue(solid_hue),
    .out_valid(out_valid), .pixel_out(pixel_out), .pass_thru(pass_thru), .sof_seen(sof_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] row, col;
    logic [8:0]  hue;
    logic [14:0] sv;
    logic        ken;
    logic [1:0]  mode;
    logic [8:0]  lo, hi;
    logic [6:0]  smin;
    logic [8:0]  solid;
    logic [23:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] kb(input int bg);
    logic [8:0] h;
    h = 9'(bg);
    return {h, ONES};
  endfunction

  task automatic add(input int r, input int c, input int h, input logic [14:0] sv,
                     input logic ken, input int md, input int lo, input int hi,
                     input int smin, input int solid, input logic [23:0] exp);
    vec_t v;
    v.row = 13'(r); v.col = 13'(c); v.hue = 9'(h); v.sv = sv; v.ken = ken;
    v.mode = 2'(md); v.lo = 9'(lo); v.hi = 9'(hi); v.smin = 7'(smin);
    v.solid = 9'(solid); v.exp = exp;
    tv.push_back(v);
  endtask

  // Mid-frame rows carry hostile config that must be ignored until the next SOF.
  task automatic add_mid(input int r, input int c, input int h, input logic [14:0] sv,
                         input logic [23:0] exp);
    add(r, c, h, sv, 1'b0, 3, 0, 0, 127, 7, exp);
  endtask

  task automatic drive(input vec_t v, input logic [23:0] pass);
    in_valid = 1'b1; row = v.row; col = v.col; pixel_in = {v.hue, v.sv}; pass_in = pass;
    key_en = v.ken; mode = v.mode; hue_lo = v.lo; hue_hi = v.hi; sat_min = v.smin;
    solid_hue = v.solid;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic send_one(input string nm, input vec_t v);
    drive(v, 24'h5A5A5A);
    step(); idle(); step(); step();
    chk({nm, "_vld"}, 32'(out_valid), 32'd1);
    chk(nm, 32'(pixel_out), 32'(v.exp));
  endtask

  initial begin
    vec_t v;
    int n;
    rst = 1'b1; in_valid = 1'b0; row = '0; col = '0; pixel_in = '0; pass_in = '0;
    key_en = 1'b0; mode = '0; hue_lo = '0; hue_hi = '0; sat_min = '0; solid_hue = '0;
    step(); step();
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_pix", 32'(pixel_out), 0);
    chk("rst_pass", 32'(pass_thru), 0);
    chk("rst_sof", 32'(sof_seen), 0);
    rst = 1'b0;

    // Before any SOF keying is off even with a matching window.
    add(5, 10, 120, SV, 1'b1, 0, 90, 150, 0, 0, {9'd120, SV});
    v = tv.pop_back();
    drive(v, 24'h123456);
    step(); idle();
    chk("lat1_vld", 32'(out_valid), 0);
    step();
    chk("lat2_vld", 32'(out_valid), 0);
    step();
    chk("lat3_vld", 32'(out_valid), 1);
    chk("nosof_pix", 32'(pixel_out), 32'(v.exp));
    chk("nosof_pass", 32'(pass_thru), 32'h123456);
    chk("nosof_seen", 32'(sof_seen), 0);
    step();
    chk("lat4_vld", 32'(out_valid), 0);

    add(0, 0, 120, SV, 1'b1, 0, 90, 150, 0, 0, kb(0));
    add_mid(5, 10, 120, SV, kb(15));
    add_mid(5, 10, 200, SV, {9'd200, SV});
    add_mid(100, 300, 90, SV, kb(40));
    add_mid(100, 300, 150, SV, kb(40));
    add_mid(0, 1, 89, SV, {9'd89, SV});
    add_mid(0, 2, 151, SV, {9'd151, SV});
    add_mid(8191, 8191, 100, SV, kb(182));
    add(0, 0, 350, SV, 1'b1, 0, 340, 20, 64, 0, kb(0));
    add_mid(1, 1, 10, SV, kb(2));
    add_mid(1, 1, 30, SV, {9'd30, SV});
    add_mid(1, 1, 350, 15'h3F12, {9'd350, 15'h3F12});
    add_mid(1, 1, 20, 15'h4012, kb(2));
    add_mid(1, 1, 340, SV, kb(2));
    add(0, 0, 5, SV, 1'b1, 2, 0, 359, 0, 500, {9'd500, ONES});
    add(0, 0, 150, SV, 1'b1, 3, 100, 200, 0, 0, 24'hFFFFFF);
    add_mid(2, 2, 50, SV, 24'h000000);
    add(0, 0, 150, SV, 1'b0, 0, 100, 200, 0, 0, {9'd150, SV});

    n = tv.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drive(tv[i], 24'hA50000 | 24'(i));
      else idle();
      step();
      if (i >= 2) begin
        chk($sformatf("tbl%0d_vld", i - 2), 32'(out_valid), 1);
        chk($sformatf("tbl%0d_pix", i - 2), 32'(pixel_out), 32'(tv[i-2].exp));
        chk($sformatf("tbl%0d_pass", i - 2), 32'(pass_thru), 32'(24'hA50000 | 24'(i - 2)));
      end
    end
    step();
    chk("tbl_drain_vld", 32'(out_valid), 0);
    chk("sof_seen_set", 32'(sof_seen), 1);

    // Scrolling phase: +4 per mode-1 SOF, held on other modes, wraps 356 -> 0.
    tv.delete();
    for (int k = 1; k <= 3; k++) begin
      add(0, 0, 100, SV, 1'b1, 1, 0, 359, 0, 0, kb(4 * k));
      send_one($sformatf("scroll%0d", k), tv.pop_back());
    end
    add(0, 0, 100, SV, 1'b1, 0, 0, 359, 0, 0, kb(12));
    send_one("scroll_hold", tv.pop_back());
    add_mid(3, 4, 100, SV, kb(19));
    send_one("scroll_mid", tv.pop_back());
    for (int k = 4; k <= 90; k++) begin
      add(0, 0, 100, SV, 1'b1, 1, 0, 359, 0, 0, kb((4 * k) % 360));
      send_one($sformatf("scroll%0d", k), tv.pop_back());
    end

    // Reset with three valid pixels in flight.
    add(0, 0, 100, SV, 1'b1, 0, 0, 359, 0, 0, kb(0));
    send_one("pre_rst_sof", tv.pop_back());
    add_mid(1, 1, 100, SV, kb(2));
    v = tv.pop_back();
    drive(v, 24'h111111); step();
    drive(v, 24'h222222); step();
    drive(v, 24'h333333); rst = 1'b1; step();
    rst = 1'b0; idle();
    chk("rst_mid_pix", 32'(pixel_out), 0);
    chk("rst_mid_pass", 32'(pass_thru), 0);
    chk("rst_mid_sof", 32'(sof_seen), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_mid_vld%0d", i), 32'(out_valid), 0);
      step();
    end
    add(1, 1, 100, SV, 1'b1, 0, 0, 359, 0, 0, {9'd100, SV});
    send_one("post_rst_nokey", tv.pop_back());
    chk("post_rst_sof", 32'(sof_seen), 0);
    add(0, 0, 100, SV, 1'b1, 0, 0, 359, 0, 0, kb(0));
    send_one("post_rst_key", tv.pop_back());
    chk("post_rst_sof2", 32'(sof_seen), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
